// File: rtl/oob_dev.sv
// ----------------------------------------------------------------------------
// oob_dev: SATA device-side out-of-band (OOB) sequencer and link bring-up.
//
// Waits for a host COMRESET, answers with COMINIT, waits for a host COMWAKE,
// answers with COMWAKE, then runs ALIGNp/SYNCp speed negotiation until the
// link is up. Once the link is up, link-layer tx data passes through to the
// GTX with one cycle of latency. All outputs are registered.
//
// Ports
//   clk              sata user clock (usrclk2)
//   rst              asynchronous active-low reset
//   gtx_ready        all GTX resets done
//   rxcominitdet_in  host COMRESET detected
//   rxcomwakedet_in  host COMWAKE detected
//   rxelecidle_in    rx line idle
//   txcomfinish_in   GTX finished requested OOB burst (pulse)
//   txcominit        request COMINIT burst (pulse)
//   txcomwake        request COMWAKE burst (pulse)
//   txelecidle       hold tx line idle
//   txdata_in        link-layer tx data
//   txcharisk_in     link-layer tx K flags
//   txdata_out       tx data to GTX
//   txcharisk_out    tx K flags to GTX
//   rxdata_in        rx data from GTX
//   rxcharisk_in     rx K flags from GTX
//   rxbyteisaligned  GTX comma alignment achieved
//   phy_ready        link usable
//   link_up          pulse when the link comes up
//   link_down        pulse when the link is lost
//   oob_error        pulse on OOB timeout
// ----------------------------------------------------------------------------
module oob_dev #(
    parameter int unsigned DATA_BYTE_WIDTH = 4,     // only 4 is supported
    parameter int unsigned CLK_SPEED_GRADE = 1,     // 1 = 75 MHz, 2 = 150 MHz, 4 = 300 MHz
    parameter int unsigned TIMEOUT_CYCLES  = 66000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         gtx_ready,
    input  logic                         rxcominitdet_in,
    input  logic                         rxcomwakedet_in,
    input  logic                         rxelecidle_in,
    input  logic                         txcomfinish_in,
    output logic                         txcominit,
    output logic                         txcomwake,
    output logic                         txelecidle,
    input  logic [DATA_BYTE_WIDTH*8-1:0] txdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]   txcharisk_in,
    output logic [DATA_BYTE_WIDTH*8-1:0] txdata_out,
    output logic [DATA_BYTE_WIDTH-1:0]   txcharisk_out,
    input  logic [DATA_BYTE_WIDTH*8-1:0] rxdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]   rxcharisk_in,
    input  logic                         rxbyteisaligned,
    output logic                         phy_ready,
    output logic                         link_up,
    output logic                         link_down,
    output logic                         oob_error
);

    localparam int unsigned DW = DATA_BYTE_WIDTH * 8;
    localparam int unsigned KW = DATA_BYTE_WIDTH;

    localparam logic [DW-1:0] ALIGN_DATA = 32'h7B4A4ABC;
    localparam logic [KW-1:0] ALIGN_K    = 4'b0001;
    localparam logic [DW-1:0] SYNC_DATA  = 32'hB5B5957C;
    localparam logic [KW-1:0] SYNC_K     = 4'b0001;

    // Timeout fires on the edge where the counter would reach the limit, so
    // the pulse lands exactly TIMEOUT_CYCLES*CLK_SPEED_GRADE cycles after entry.
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES * CLK_SPEED_GRADE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSendCominit,
        StWaitComwake,
        StSendComwake,
        StWaitRelease,
        StSendAlign,
        StSendSync,
        StLink
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_rst_meta, r_run;
    logic [19:0]     r_tmo, w_tmo_nxt;
    logic [1:0]      r_sync_cnt, w_sync_cnt_nxt;

    logic            w_trans;        // a transition (including re-entry) is taken
    logic            w_rx_align;
    logic            w_counting;
    logic            w_tmo_hit;
    logic            w_link_up, w_link_down, w_oob_error;

    logic            r_txcominit, r_txcomwake, r_txelecidle, r_phy_ready;
    logic            r_link_up, r_link_down, r_oob_error;
    logic [DW-1:0]   r_txdata, w_txdata_nxt;
    logic [KW-1:0]   r_txcharisk, w_txcharisk_nxt;

    assign w_rx_align = (rxdata_in == ALIGN_DATA) && (rxcharisk_in == ALIGN_K);
    assign w_counting = (r_state != StIdle) && (r_state != StLink);
    assign w_tmo_hit  = (r_tmo == TMO_LAST);

    // Reset release is resynchronised; the FSM only moves once r_run is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_meta <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_run      <= r_rst_meta;
        end
    end

    // Next-state logic. Priority: gtx_ready loss, COMRESET, timeout, normal.
    always_comb begin
        w_state_nxt = r_state;
        w_trans     = 1'b0;
        w_link_up   = 1'b0;
        w_link_down = 1'b0;
        w_oob_error = 1'b0;
        if (!r_run) begin
            w_state_nxt = StIdle;
        end else if (!gtx_ready) begin
            if (r_state != StIdle) begin
                w_state_nxt = StIdle;
                w_trans     = 1'b1;
            end
            w_link_down = (r_state == StLink);
        end else if (rxcominitdet_in) begin
            w_state_nxt = StSendCominit;
            w_trans     = 1'b1;
            w_link_down = (r_state == StLink);
        end else if (w_counting && w_tmo_hit) begin
            w_state_nxt = StIdle;
            w_trans     = 1'b1;
            w_oob_error = 1'b1;
        end else begin
            case (r_state)
                StSendCominit: begin
                    if (txcomfinish_in) begin
                        w_state_nxt = StWaitComwake;
                        w_trans     = 1'b1;
                    end
                end
                StWaitComwake: begin
                    if (rxcomwakedet_in) begin
                        w_state_nxt = StSendComwake;
                        w_trans     = 1'b1;
                    end
                end
                StSendComwake: begin
                    if (txcomfinish_in) begin
                        w_state_nxt = StWaitRelease;
                        w_trans     = 1'b1;
                    end
                end
                StWaitRelease: begin
                    if (!rxelecidle_in) begin
                        w_state_nxt = StSendAlign;
                        w_trans     = 1'b1;
                    end
                end
                StSendAlign: begin
                    if (rxbyteisaligned && w_rx_align) begin
                        w_state_nxt = StSendSync;
                        w_trans     = 1'b1;
                    end
                end
                StSendSync: begin
                    // Third consecutive aligned non-ALIGNp word.
                    if (rxbyteisaligned && !w_rx_align && (r_sync_cnt == 2'd2)) begin
                        w_state_nxt = StLink;
                        w_trans     = 1'b1;
                        w_link_up   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timeout and SYNC counters, both cleared on any transition.
    always_comb begin
        w_tmo_nxt      = '0;
        w_sync_cnt_nxt = '0;
        if (!w_trans) begin
            if (w_counting) begin
                w_tmo_nxt = r_tmo + 20'd1;
            end
            if (r_state == StSendSync) begin
                if (w_rx_align) begin
                    w_sync_cnt_nxt = '0;
                end else if (rxbyteisaligned) begin
                    w_sync_cnt_nxt = r_sync_cnt + 2'd1;
                end else begin
                    w_sync_cnt_nxt = r_sync_cnt;
                end
            end
        end
    end

    // Tx data follows the state being entered so it lines up with txelecidle.
    always_comb begin
        w_txdata_nxt    = '0;
        w_txcharisk_nxt = '0;
        case (w_state_nxt)
            StSendAlign: begin
                w_txdata_nxt    = ALIGN_DATA;
                w_txcharisk_nxt = ALIGN_K;
            end
            StSendSync: begin
                w_txdata_nxt    = SYNC_DATA;
                w_txcharisk_nxt = SYNC_K;
            end
            StLink: begin
                w_txdata_nxt    = txdata_in;
                w_txcharisk_nxt = txcharisk_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_tmo        <= '0;
            r_sync_cnt   <= '0;
            r_txcominit  <= 1'b0;
            r_txcomwake  <= 1'b0;
            r_txelecidle <= 1'b1;
            r_phy_ready  <= 1'b0;
            r_link_up    <= 1'b0;
            r_link_down  <= 1'b0;
            r_oob_error  <= 1'b0;
            r_txdata     <= '0;
            r_txcharisk  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_tmo        <= w_tmo_nxt;
            r_sync_cnt   <= w_sync_cnt_nxt;
            r_txcominit  <= w_trans && (w_state_nxt == StSendCominit);
            r_txcomwake  <= w_trans && (w_state_nxt == StSendComwake);
            r_txelecidle <= !((w_state_nxt == StSendAlign) || (w_state_nxt == StSendSync) ||
                              (w_state_nxt == StLink));
            r_phy_ready  <= (w_state_nxt == StLink) && gtx_ready && rxbyteisaligned;
            r_link_up    <= w_link_up;
            r_link_down  <= w_link_down;
            r_oob_error  <= w_oob_error;
            r_txdata     <= w_txdata_nxt;
            r_txcharisk  <= w_txcharisk_nxt;
        end
    end

    assign txcominit     = r_txcominit;
    assign txcomwake     = r_txcomwake;
    assign txelecidle    = r_txelecidle;
    assign phy_ready     = r_phy_ready;
    assign link_up       = r_link_up;
    assign link_down     = r_link_down;
    assign oob_error     = r_oob_error;
    assign txdata_out    = r_txdata;
    assign txcharisk_out = r_txcharisk;

endmodule

// File: doc/oob_dev.md
OOB_DEV -- requirements
Module: oob_dev

Interface
REQ-001 SHALL have parameter DATA_BYTE_WIDTH, default 4, bytes per data word; only 4 is supported.
REQ-002 SHALL have parameter CLK_SPEED_GRADE, default 1, clock grade (1 = 75 MHz, 2 = 150 MHz, 4 = 300 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 66000, base timeout; effective timeout = TIMEOUT_CYCLES*CLK_SPEED_GRADE cycles.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sata clock (usrclk2); one clock only.
- rst  in  1  reset, asynchronous, active-low.
- gtx_ready  in  1  all GTX resets are done.
- rxcominitdet_in  in  1  host COMRESET detected.
- rxcomwakedet_in  in  1  host COMWAKE detected.
- rxelecidle_in  in  1  rx line idle.
- txcomfinish_in  in  1  GTX finished the requested OOB burst (1-cycle pulse).
- txcominit  out  1  issue COMINIT.
- txcomwake  out  1  issue COMWAKE.
- txelecidle  out  1  hold tx line idle.
- txdata_in  in  32  link-layer tx data.
- txcharisk_in  in  4  link-layer tx K flags.
- txdata_out  out  32  data to GTX.
- txcharisk_out  out  4  K flags to GTX.
- rxdata_in  in  32  data from GTX.
- rxcharisk_in  in  4  K flags from GTX.
- rxbyteisaligned  in  1  GTX comma alignment achieved.
- phy_ready  out  1  link usable.
- link_up  out  1  1-cycle pulse when the link is established.
- link_down  out  1  1-cycle pulse when the link is lost.
- oob_error  out  1  1-cycle pulse on timeout.

Function
REQ-005 SHALL implement the FSM states IDLE, SEND_COMINIT, WAIT_COMWAKE, SEND_COMWAKE, WAIT_RELEASE, SEND_ALIGN, SEND_SYNC and LINK; all outputs registered.
REQ-006 Primitives: ALIGNp = 32'h7B4A4ABC/4'b0001, SYNCp = 32'hB5B5957C/4'b0001; an rx match requires both data and K flags equal.
REQ-007 IDLE: when gtx_ready=1 and rxcominitdet_in=1, go to SEND_COMINIT.
REQ-008 SEND_COMINIT: txcominit=1 for exactly the first cycle after entry; on txcomfinish_in, go to WAIT_COMWAKE.
REQ-009 WAIT_COMWAKE: on rxcomwakedet_in, go to SEND_COMWAKE; on rxcominitdet_in, re-enter SEND_COMINIT (retry); if both occur in the same cycle, rxcominitdet_in wins.
REQ-010 SEND_COMWAKE: txcomwake=1 for exactly one cycle after entry; on txcomfinish_in, go to WAIT_RELEASE.
REQ-011 WAIT_RELEASE: when rxelecidle_in=0, go to SEND_ALIGN.
REQ-012 txelecidle=1 in IDLE through WAIT_RELEASE, and 0 in SEND_ALIGN, SEND_SYNC and LINK.
REQ-013 Before SEND_ALIGN, txdata_out=0 and txcharisk_out=0.
REQ-014 SEND_ALIGN: transmit ALIGNp every cycle; when rxbyteisaligned=1 and rx==ALIGNp, go to SEND_SYNC.
REQ-015 SEND_SYNC: transmit SYNCp; a 2-bit counter counts consecutive rx non-ALIGNp words with rxbyteisaligned=1; an ALIGNp clears it; a count of 3 causes a go to LINK with a link_up pulse.
REQ-016 LINK: txdata_out/txcharisk_out = txdata_in/txcharisk_in, delayed 1 cycle.
REQ-017 phy_ready = (state==LINK) & gtx_ready & rxbyteisaligned.
REQ-018 LINK exit on rxcominitdet_in: pulse link_down and go to SEND_COMINIT.
REQ-019 LINK exit on gtx_ready=0: pulse link_down and go to IDLE; this takes priority over REQ-018.
REQ-020 gtx_ready=0 in any non-LINK state: go to IDLE with no pulses.
REQ-021 Timeout: a 20-bit counter runs in SEND_COMINIT, WAIT_COMWAKE, SEND_COMWAKE, WAIT_RELEASE, SEND_ALIGN and SEND_SYNC, and clears on every state change (including a re-entry).
REQ-022 When the timeout counter reaches the effective timeout, pulse oob_error and go to IDLE.
REQ-023 rxcominitdet_in in any state other than IDLE/LINK restarts at SEND_COMINIT; this takes priority over a timeout in the same cycle.

Reset
REQ-024 While rst=0 (asynchronous): state=IDLE, counters=0, txelecidle=1, and all other outputs=0.
REQ-025 Release of rst SHALL be sampled synchronously; the first transition can occur no earlier than the second rising edge after release.

Verification (TIMEOUT_CYCLES=64, CLK_SPEED_GRADE=1)
REQ-026 Normal bring-up: COMRESET -> txcominit pulse; txcomfinish -> COMWAKE det -> txcomwake pulse; txcomfinish -> rxelecidle=0 -> ALIGNp out; ALIGNp in -> SYNCp out; 3 non-ALIGN words -> link_up pulse, phy_ready=1, tx passthrough 1-cycle latency.
REQ-027 No COMWAKE after COMINIT -> oob_error pulse exactly 64 cycles after WAIT_COMWAKE entry, state IDLE, txelecidle=1.
REQ-028 SEND_SYNC with the pattern non-ALIGN, non-ALIGN, ALIGNp, then 3 non-ALIGN -> link_up only after the final 3.
REQ-029 In LINK: COMRESET -> link_down pulse, phy_ready=0 next cycle, txcominit pulse; gtx_ready drop -> link_down, IDLE.
REQ-030 rst=0 asserted mid-SEND_ALIGN -> txelecidle=1 and txdata_out=0 immediately, without waiting for clk.
REQ-031 rxcominitdet_in together with rxcomwakedet_in in WAIT_COMWAKE -> second txcominit pulse, no txcomwake.
